tick_divider_chain: RTL and testbench

TICK_DIVIDER_CHAIN -- requirements
Module: tick_divider_chain

---
 rtl/tick_divider_chain.sv | 78 +++++++
 tb/tb_tick_divider_chain.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tick_divider_chain.sv
// Programmable prescaler followed by a cascade of fixed-ratio tick stages.
// Each stage emits a one-cycle tick and a 50% square wave derived from it.
module tick_divider_chain #(
   parameter int CLK_DIV     = 100_000,
   parameter int NUM_STAGES  = 4,
   parameter int STAGE_RATIO = 10,
   parameter int DIV_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  div_load,
   input  logic [DIV_W-1:0]      div_value,
   output logic [NUM_STAGES-1:0] tick,
   output logic [NUM_STAGES-1:0] square
);

   localparam int SC_W = (STAGE_RATIO > 1) ? $clog2(STAGE_RATIO) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(STAGE_RATIO - 1);

   logic [DIV_W-1:0]      div_reg;
   logic [DIV_W-1:0]      pc;
   logic [SC_W-1:0]       sc [NUM_STAGES];
   logic                  pc_last;
   logic [NUM_STAGES-1:0] wrap;

   // div_reg is never 0, so div_reg-1 cannot underflow.
   assign pc_last = (pc == div_reg - DIV_W'(1));

   always_comb begin
      wrap    = '0;
      wrap[0] = enable && pc_last;
      for (int k = 1; k < NUM_STAGES; k++) begin
         wrap[k] = wrap[k-1] && (sc[k] == SC_LAST);
      end
   end

   // sc[0] exists only to keep indexing uniform; the prescaler plays its role.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_reg <= DIV_W'(CLK_DIV);
         pc      <= '0;
         tick    <= '0;
         square  <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            sc[k] <= '0;
         end
      end else begin
         if (div_load) begin
            div_reg <= (div_value == '0) ? DIV_W'(1) : div_value;
         end
         if (clear) begin
            pc     <= '0;
            tick   <= '0;
            square <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
               sc[k] <= '0;
            end
         end else if (div_load) begin
            pc   <= '0;
            tick <= '0;
         end else if (enable) begin
            pc     <= pc_last ? '0 : pc + DIV_W'(1);
            tick   <= wrap;
            square <= square ^ wrap;
            for (int k = 1; k < NUM_STAGES; k++) begin
               if (wrap[k-1]) begin
                  sc[k] <= (sc[k] == SC_LAST) ? '0 : sc[k] + SC_W'(1);
               end
            end
         end else begin
            tick <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tick_divider_chain.sv
// Bench for tick_divider_chain: a tick-count reference model feeds a scoreboard
// queue that a negedge monitor drains, plus a few directed point checks.
module tb_tick_divider_chain;

   localparam int CLK_DIV = 4;
   localparam int NS      = 3;
   localparam int R       = 3;
   localparam int DIV_W   = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic             clear;
   logic             div_load;
   logic [DIV_W-1:0] div_value;
   logic [NS-1:0]    tick;
   logic [NS-1:0]    square;

   int n_checks = 0;
   int n_pass   = 0;

   logic [2*NS-1:0] sb_q [$];
   logic [2*NS-1:0] last_exp;

   // Reference state: divisor, enabled cycles into the current period, and
   // total tick[0] pulses since the last clear/reset.
   int m_div, m_ph, m_n0;

   tick_divider_chain #(
      .CLK_DIV(CLK_DIV), .NUM_STAGES(NS), .STAGE_RATIO(R), .DIV_W(DIV_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .div_load(div_load), .div_value(div_value), .tick(tick), .square(square)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int rpow(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * R;
      return p;
   endfunction

   task automatic model_step();
      logic [NS-1:0] et;
      logic [NS-1:0] es;
      et = '0;
      if (!rst) begin
         m_div = CLK_DIV; m_ph = 0; m_n0 = 0;
      end else begin
         if (div_load) m_div = (div_value == 0) ? 1 : int'(div_value);
         if (clear) begin
            m_ph = 0; m_n0 = 0;
         end else if (div_load) begin
            m_ph = 0;
         end else if (enable) begin
            m_ph++;
            if (m_ph == m_div) begin
               m_ph = 0;
               m_n0++;
               for (int k = 0; k < NS; k++) et[k] = (m_n0 % rpow(k)) == 0;
            end
         end
      end
      for (int k = 0; k < NS; k++) es[k] = ((m_n0 / rpow(k)) % 2) == 1;
      last_exp = {et, es};
      sb_q.push_back({et, es});
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         logic [2*NS-1:0] e;
         e = sb_q.pop_front();
         n_checks++;
         if ({tick, square} === e) n_pass++;
         else $display("FAIL scoreboard t=%0t: tick/square got %b/%b expected %b/%b",
                       $time, tick, square, e[2*NS-1:NS], e[NS-1:0]);
      end
   end

   initial begin
      bit found;
      rst = 1'b0; enable = 1'b0; clear = 1'b0; div_load = 1'b0; div_value = '0;
      repeat (3) cycle();
      chk("reset_outputs", {26'd0, tick, square}, 32'd0);

      // Release with enable high: tick[0] at edges 4,8,12; tick[1] at 12; tick[2] at 36.
      rst = 1'b1; enable = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         cycle();
         if (n == 3)  chk("first_tick_not_early", 32'(tick), 32'd0);
         if (n == 4)  chk("first_tick0", 32'(tick), 32'b001);
         if (n == 4)  chk("square0_rise", 32'(square[0]), 32'd1);
         if (n == 8)  chk("square0_fall", 32'(square[0]), 32'd0);
         if (n == 12) chk("first_tick1", 32'(tick), 32'b011);
         if (n == 36) chk("first_tick2", 32'(tick), 32'b111);
      end

      // Enable gap at pc=2.
      clear = 1'b1; cycle(); clear = 1'b0;
      cycle(); cycle();
      enable = 1'b0;
      for (int n = 0; n < 7; n++) begin
         cycle();
         chk("gap_no_tick", 32'(tick), 32'd0);
      end
      enable = 1'b1;
      cycle();
      chk("reenable_one", 32'(tick[0]), 32'd0);
      cycle();
      chk("reenable_two", 32'(tick[0]), 32'd1);

      // Divisor change mid-period.
      cycle();
      div_load = 1'b1; div_value = 8'd2; cycle(); div_load = 1'b0;
      chk("load_no_tick", 32'(tick), 32'd0);
      repeat (8) cycle();

      // Divisor 0 behaves as 1.
      div_load = 1'b1; div_value = 8'd0; cycle(); div_load = 1'b0;
      for (int n = 0; n < 9; n++) begin
         cycle();
         chk("div1_every_cycle", 32'(tick[0]), 32'd1);
      end

      // Clear together with a load.
      clear = 1'b1; div_load = 1'b1; div_value = 8'd5; cycle();
      clear = 1'b0; div_load = 1'b0;
      chk("clear_load_zero", {26'd0, tick, square}, 32'd0);
      for (int n = 1; n <= 5; n++) begin
         cycle();
         if (n == 4) chk("clear_load_t4", 32'(tick[0]), 32'd0);
         if (n == 5) chk("clear_load_t5", 32'(tick[0]), 32'd1);
      end

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         enable    = ($urandom_range(0, 9) != 0);
         clear     = ($urandom_range(0, 99) == 0);
         div_load  = ($urandom_range(0, 49) == 0);
         div_value = DIV_W'($urandom_range(0, 6));
         cycle();
      end
      enable = 1'b1; clear = 1'b0; div_load = 1'b0;

      // Async reset while tick[1] is high.
      div_load = 1'b1; div_value = 8'd1; cycle(); div_load = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         cycle();
         if (last_exp[NS+1]) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         $display("FAIL find_tick1: got none expected tick[1] within 100 cycles");
      end
      #2 rst = 1'b0;
      #1;
      chk("async_rst_tick", 32'(tick), 32'd0);
      chk("async_rst_square", 32'(square), 32'd0);
      @(negedge clk);
      cycle();
      rst = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         cycle();
         if (n == 3) chk("post_rst_t3", 32'(tick), 32'd0);
         if (n == 4) chk("post_rst_div4", 32'(tick), 32'b001);
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
